// File: rtl/ff_array_arb_pkg.sv
// Shared types and helpers for the flip-flop array port arbiter.
//   arb_state_t : arbiter mode (normal arbitration or array flush)
//   port_own_t  : per-port record of who was granted and whether a read
//                 response is owed in the following cycle
//   rr_next     : round-robin successor of a requester index
package ff_array_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } arb_state_t;

    // Owner field is fixed-width so the struct can live in the package;
    // it comfortably covers any practical requester count.
    localparam int OWNER_W = 8;

    typedef struct packed {
        logic               valid;
        logic               is_read;
        logic [OWNER_W-1:0] owner;
    } port_own_t;

    function automatic int rr_next(input int idx, input int n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/ff_array_rr_pick.sv
// Combinational two-grant round-robin selector.
//   eligible : requesters that may be granted this cycle
//   rr_ptr   : first requester index to consider
//   gnt0     : one-hot first grant in scan order (zero if none)
//   gnt1     : one-hot second grant in scan order (zero if none)
//   idx0     : binary index of gnt0
//   idx1     : binary index of gnt1
//   next_ptr : one past the last grant, or rr_ptr when nothing is granted
module ff_array_rr_pick
    import ff_array_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         eligible,
    input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
    output logic [NUM_REQ-1:0]         gnt0,
    output logic [NUM_REQ-1:0]         gnt1,
    output logic [$clog2(NUM_REQ)-1:0] idx0,
    output logic [$clog2(NUM_REQ)-1:0] idx1,
    output logic [$clog2(NUM_REQ)-1:0] next_ptr
);

    localparam int PW = $clog2(NUM_REQ);

    logic [PW-1:0] scan;

    always_comb begin
        gnt0     = '0;
        gnt1     = '0;
        idx0     = '0;
        idx1     = '0;
        scan     = '0;
        next_ptr = rr_ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan = PW'((int'(rr_ptr) + i) % NUM_REQ);
            if (eligible[scan]) begin
                if (gnt0 == '0) begin
                    gnt0[scan] = 1'b1;
                    idx0       = scan;
                end else if (gnt1 == '0) begin
                    gnt1[scan] = 1'b1;
                    idx1       = scan;
                end
            end
        end
        if (|gnt1) begin
            next_ptr = PW'(rr_next(int'(idx1), NUM_REQ));
        end else if (|gnt0) begin
            next_ptr = PW'(rr_next(int'(idx0), NUM_REQ));
        end
    end

endmodule

// File: rtl/ff_array_port_arbiter.sv
// Shares one dual-port flip-flop array among NUM_REQ requesters.
// Up to two requests are granted per cycle in round-robin order and steered
// onto the two array ports so the array's hazard rules are never hit; read
// data is routed back to its owner one cycle later. A flush writes FLUSH_VAL
// to every entry, two entries per cycle.
//   clk, rst_n                      : clock, async active-low reset
//   req_valid/we/addr/wdata         : per-requester request
//   req_ready                       : per-requester grant (combinational)
//   resp_valid/resp_rdata           : per-requester read response
//   flush_req/flush_busy/flush_done : flush start, in-progress, completion pulse
//   arr_*0, arr_*1                  : array ports 0 and 1 (active-low csb/web)
module ff_array_port_arbiter
    import ff_array_arb_pkg::*;
#(
    parameter int               NUM_REQ   = 4,
    parameter int               S_INDEX   = 4,
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] FLUSH_VAL = '0
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ-1:0]              req_we,
    input  logic [NUM_REQ-1:0][S_INDEX-1:0] req_addr,
    input  logic [NUM_REQ-1:0][WIDTH-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic [NUM_REQ-1:0]              resp_valid,
    output logic [NUM_REQ-1:0][WIDTH-1:0]   resp_rdata,
    input  logic                            flush_req,
    output logic                            flush_busy,
    output logic                            flush_done,
    output logic                            arr_csb0,
    output logic                            arr_web0,
    output logic [S_INDEX-1:0]              arr_addr0,
    output logic [WIDTH-1:0]                arr_din0,
    input  logic [WIDTH-1:0]                arr_dout0,
    output logic                            arr_csb1,
    output logic                            arr_web1,
    output logic [S_INDEX-1:0]              arr_addr1,
    output logic [WIDTH-1:0]                arr_din1,
    input  logic [WIDTH-1:0]                arr_dout1
);

    localparam int NUM_SETS = 2 ** S_INDEX;
    localparam int PW       = $clog2(NUM_REQ);
    // A single-bit counter stands in for the zero-width case S_INDEX == 1.
    localparam int CW       = (S_INDEX > 1) ? S_INDEX - 1 : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NUM_SETS / 2 - 1);

    arb_state_t      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic            done_q, done_d;
    port_own_t [1:0] own_q, own_d;

    logic [NUM_REQ-1:0] pick_gnt0, pick_gnt1;
    logic [PW-1:0]      pick_idx0, pick_idx1, pick_next;
    logic               take0, take1, wr_conflict;
    logic [PW-1:0]      p0, p1;
    logic [CW:0]        flush_addr0, flush_addr1;

    ff_array_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .eligible (req_valid),
        .rr_ptr   (ptr_q),
        .gnt0     (pick_gnt0),
        .gnt1     (pick_gnt1),
        .idx0     (pick_idx0),
        .idx1     (pick_idx1),
        .next_ptr (pick_next)
    );

    // Two writes to one address would corrupt the entry, so the later one in
    // scan order is dropped and retried on a following cycle.
    assign wr_conflict = (|pick_gnt1) && req_we[pick_idx0] && req_we[pick_idx1] &&
                         (req_addr[pick_idx0] == req_addr[pick_idx1]);
    assign take0 = |pick_gnt0;
    assign take1 = (|pick_gnt1) && !wr_conflict;

    assign flush_addr0 = {cnt_q, 1'b0};
    assign flush_addr1 = {cnt_q, 1'b1};

    // Next-state and array/grant outputs. For a mixed read/write pair the
    // read must sit on port 0, the only port that sees a same-cycle write on
    // the other port. Outputs are forced idle while reset is held.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        done_d    = 1'b0;
        own_d     = '0;
        req_ready = '0;
        p0        = pick_idx0;
        p1        = pick_idx1;
        arr_csb0  = 1'b1;
        arr_web0  = 1'b1;
        arr_addr0 = '0;
        arr_din0  = '0;
        arr_csb1  = 1'b1;
        arr_web1  = 1'b1;
        arr_addr1 = '0;
        arr_din1  = '0;
        case (state_q)
            IDLE: begin
                if (flush_req) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end else if (take0) begin
                    req_ready = pick_gnt0 | (take1 ? pick_gnt1 : '0);
                    ptr_d     = take1 ? pick_next : PW'(rr_next(int'(pick_idx0), NUM_REQ));
                    if (take1 && req_we[pick_idx0] && !req_we[pick_idx1]) begin
                        p0 = pick_idx1;
                        p1 = pick_idx0;
                    end
                    arr_csb0  = 1'b0;
                    arr_web0  = ~req_we[p0];
                    arr_addr0 = req_addr[p0];
                    arr_din0  = req_we[p0] ? req_wdata[p0] : '0;
                    own_d[0]  = '{valid: 1'b1, is_read: ~req_we[p0], owner: OWNER_W'(p0)};
                    if (take1) begin
                        arr_csb1  = 1'b0;
                        arr_web1  = ~req_we[p1];
                        arr_addr1 = req_addr[p1];
                        arr_din1  = req_we[p1] ? req_wdata[p1] : '0;
                        own_d[1]  = '{valid: 1'b1, is_read: ~req_we[p1], owner: OWNER_W'(p1)};
                    end
                end
            end
            FLUSH: begin
                arr_csb0  = 1'b0;
                arr_web0  = 1'b0;
                arr_addr0 = flush_addr0[S_INDEX-1:0];
                arr_din0  = FLUSH_VAL;
                arr_csb1  = 1'b0;
                arr_web1  = 1'b0;
                arr_addr1 = flush_addr1[S_INDEX-1:0];
                arr_din1  = FLUSH_VAL;
                if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (!rst_n) begin
            req_ready = '0;
            arr_csb0  = 1'b1;
            arr_web0  = 1'b1;
            arr_addr0 = '0;
            arr_din0  = '0;
            arr_csb1  = 1'b1;
            arr_web1  = 1'b1;
            arr_addr1 = '0;
            arr_din1  = '0;
        end
    end

    // Read data from each port goes back to whoever owned that port last cycle.
    always_comb begin
        resp_valid = '0;
        resp_rdata = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (own_q[0].valid && own_q[0].is_read && own_q[0].owner == OWNER_W'(r)) begin
                resp_valid[r] = 1'b1;
                resp_rdata[r] = arr_dout0;
            end
            if (own_q[1].valid && own_q[1].is_read && own_q[1].owner == OWNER_W'(r)) begin
                resp_valid[r] = 1'b1;
                resp_rdata[r] = arr_dout1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            done_q  <= 1'b0;
            own_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            done_q  <= done_d;
            own_q   <= own_d;
        end
    end

    assign flush_busy = (state_q == FLUSH);
    assign flush_done = done_q;

endmodule

// File: tb/tb_ff_array_port_arbiter.sv
// Self-checking bench for ff_array_port_arbiter with a behavioural array
// model attached to the array ports and an abstract reference model.
module tb_ff_array_port_arbiter;

    localparam int NR = 4;
    localparam int SI = 4;
    localparam int W  = 32;
    localparam int NS = 16;
    localparam logic [W-1:0] FV = '0;

    logic                     clk;
    logic                     rst_n;
    logic [NR-1:0]            req_valid, req_we, req_ready, resp_valid;
    logic [NR-1:0][SI-1:0]    req_addr;
    logic [NR-1:0][W-1:0]     req_wdata, resp_rdata;
    logic                     flush_req, flush_busy, flush_done;
    logic                     arr_csb0, arr_web0, arr_csb1, arr_web1;
    logic [SI-1:0]            arr_addr0, arr_addr1;
    logic [W-1:0]             arr_din0, arr_din1, arr_dout0, arr_dout1;

    ff_array_port_arbiter #(.NUM_REQ(NR), .S_INDEX(SI), .WIDTH(W), .FLUSH_VAL(FV)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .flush_req(flush_req), .flush_busy(flush_busy), .flush_done(flush_done),
        .arr_csb0(arr_csb0), .arr_web0(arr_web0), .arr_addr0(arr_addr0),
        .arr_din0(arr_din0), .arr_dout0(arr_dout0),
        .arr_csb1(arr_csb1), .arr_web1(arr_web1), .arr_addr1(arr_addr1),
        .arr_din1(arr_din1), .arr_dout1(arr_dout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural flip-flop array: registered inputs, one-cycle read latency,
    // port 0 sees a same-cycle port-1 write, same-address dual write is X.
    logic [W-1:0] arr_mem [NS];
    initial begin
        for (int i = 0; i < NS; i++) arr_mem[i] = '0;
        arr_dout0 = '0;
        arr_dout1 = '0;
    end
    always @(posedge clk) begin
        if (!arr_csb0 && arr_web0)
            arr_dout0 <= (!arr_csb1 && !arr_web1 && arr_addr1 == arr_addr0) ? arr_din1 : arr_mem[arr_addr0];
        if (!arr_csb1 && arr_web1)
            arr_dout1 <= arr_mem[arr_addr1];
        if (!arr_csb0 && !arr_web0 && !arr_csb1 && !arr_web1 && arr_addr0 == arr_addr1) begin
            arr_mem[arr_addr0] <= 'x;
        end else begin
            if (!arr_csb0 && !arr_web0) arr_mem[arr_addr0] <= arr_din0;
            if (!arr_csb1 && !arr_web1) arr_mem[arr_addr1] <= arr_din1;
        end
    end

    // Reference model state
    logic [W-1:0] m_mem [NS];
    int           m_ptr;
    int           m_left;
    bit           m_done_pend;
    bit           exp_rv [NR];
    logic [W-1:0] exp_rd [NR];

    // Staged stimulus
    logic [NR-1:0]         stg_valid, stg_we;
    logic [NR-1:0][SI-1:0] stg_addr;
    logic [NR-1:0][W-1:0]  stg_wdata;
    logic                  stg_flush;

    int checks;
    int failures;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic clearStage();
        stg_valid = '0;
        stg_we    = '0;
        stg_addr  = '0;
        stg_wdata = '0;
        stg_flush = 1'b0;
    endtask

    task automatic stageReq(input int r, input bit we, input int addr, input logic [W-1:0] d);
        stg_valid[r] = 1'b1;
        stg_we[r]    = we;
        stg_addr[r]  = SI'(addr);
        stg_wdata[r] = d;
    endtask

    task automatic modelReset();
        m_ptr       = 0;
        m_left      = 0;
        m_done_pend = 0;
        for (int r = 0; r < NR; r++) exp_rv[r] = 0;
    endtask

    // One cycle: drive inputs after the falling edge, then compare against the
    // model and advance the model to what the next rising edge should commit.
    task automatic applyStimulus();
        int           a_i, b_i, n, k;
        bit           flushing, done_next;
        logic [NR-1:0] exp_ready;
        @(negedge clk);
        req_valid = stg_valid;
        req_we    = stg_we;
        req_addr  = stg_addr;
        req_wdata = stg_wdata;
        flush_req = stg_flush;
        #1;
        for (int r = 0; r < NR; r++) begin
            checkOutput($sformatf("resp_valid[%0d]", r), 64'(resp_valid[r]), 64'(exp_rv[r]));
            if (exp_rv[r]) checkOutput($sformatf("resp_rdata[%0d]", r), 64'(resp_rdata[r]), 64'(exp_rd[r]));
            exp_rv[r] = 0;
        end
        checkOutput("flush_done", 64'(flush_done), 64'(m_done_pend));
        checkOutput("flush_busy", 64'(flush_busy), 64'(m_left > 0));
        exp_ready = '0;
        n         = 0;
        done_next = 0;
        flushing  = (m_left > 0);
        a_i       = -1;
        b_i       = -1;
        if (flushing) begin
            k = NS / 2 - m_left;
            m_mem[2 * k]     = FV;
            m_mem[2 * k + 1] = FV;
            m_left--;
            if (m_left == 0) done_next = 1;
        end else if (flush_req) begin
            m_left = NS / 2;
        end else begin
            for (int i = 0; i < NR; i++) begin
                int r;
                r = (m_ptr + i) % NR;
                if (req_valid[r]) begin
                    if (a_i < 0) a_i = r;
                    else if (b_i < 0) b_i = r;
                end
            end
            if (b_i >= 0 && req_we[a_i] && req_we[b_i] && req_addr[a_i] == req_addr[b_i]) b_i = -1;
            if (a_i >= 0) begin exp_ready[a_i] = 1'b1; n = 1; m_ptr = (a_i + 1) % NR; end
            if (b_i >= 0) begin exp_ready[b_i] = 1'b1; n = 2; m_ptr = (b_i + 1) % NR; end
            if (a_i >= 0 && req_we[a_i]) m_mem[req_addr[a_i]] = req_wdata[a_i];
            if (b_i >= 0 && req_we[b_i]) m_mem[req_addr[b_i]] = req_wdata[b_i];
            if (a_i >= 0 && !req_we[a_i]) begin exp_rv[a_i] = 1; exp_rd[a_i] = m_mem[req_addr[a_i]]; end
            if (b_i >= 0 && !req_we[b_i]) begin exp_rv[b_i] = 1; exp_rd[b_i] = m_mem[req_addr[b_i]]; end
        end
        checkOutput("req_ready", 64'(req_ready), 64'(exp_ready));
        checkOutput("port0_csb", 64'(arr_csb0), 64'(!(flushing || n >= 1)));
        checkOutput("port1_csb", 64'(arr_csb1), 64'(!(flushing || n == 2)));
        if (n == 2 && req_we[a_i] != req_we[b_i])
            checkOutput("read_on_port0", 64'(arr_web0), 64'd1);
        m_done_pend = done_next;
    endtask

    task automatic checkResetOutputs(input string pfx);
        checkOutput({pfx, "_req_ready"}, 64'(req_ready), 64'd0);
        checkOutput({pfx, "_resp_valid"}, 64'(resp_valid), 64'd0);
        checkOutput({pfx, "_flush_busy"}, 64'(flush_busy), 64'd0);
        checkOutput({pfx, "_flush_done"}, 64'(flush_done), 64'd0);
        checkOutput({pfx, "_csb"}, 64'({arr_csb0, arr_csb1}), 64'd3);
        checkOutput({pfx, "_web"}, 64'({arr_web0, arr_web1}), 64'd3);
        checkOutput({pfx, "_addr"}, 64'({arr_addr0, arr_addr1}), 64'd0);
        checkOutput({pfx, "_din"}, 64'({arr_din0, arr_din1}), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        checks   = 0;
        failures = 0;
        for (int i = 0; i < NS; i++) m_mem[i] = '0;
        modelReset();

        // Reset with requests pending: everything must stay idle
        rst_n     = 1'b0;
        req_valid = '1;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '1;
        flush_req = 1'b0;
        #12;
        checkResetOutputs("reset");
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // Single read of an untouched entry
        clearStage(); stageReq(2, 0, 5, '0); applyStimulus();
        clearStage(); applyStimulus();

        // Same-address read and write in one cycle
        clearStage(); stageReq(0, 1, 3, 32'hA5); stageReq(1, 0, 3, '0); applyStimulus();
        clearStage(); applyStimulus();

        // Bring the pointer back to 0, then collide two writes on address 7
        clearStage(); stageReq(3, 0, 1, '0); applyStimulus();
        clearStage(); stageReq(0, 1, 7, 32'h1111); stageReq(1, 1, 7, 32'h2222); applyStimulus();
        clearStage(); stageReq(1, 1, 7, 32'h2222); applyStimulus();
        clearStage(); stageReq(2, 0, 7, '0); applyStimulus();
        clearStage(); applyStimulus();

        // Round-robin fairness with all requesters reading
        for (int c = 0; c < 6; c++) begin
            clearStage();
            for (int r = 0; r < NR; r++) stageReq(r, 0, 8 + r, '0);
            applyStimulus();
        end
        clearStage(); applyStimulus();

        // Fill the array with nonzero data, then flush and read back
        for (int k = 0; k < NS / 2; k++) begin
            clearStage();
            stageReq(0, 1, 2 * k, 32'hC0DE_0000 | 32'(2 * k + 1));
            stageReq(1, 1, 2 * k + 1, 32'hC0DE_0000 | 32'(2 * k + 2));
            applyStimulus();
        end
        clearStage(); stageReq(3, 0, 4, '0); applyStimulus();
        clearStage(); stg_flush = 1'b1; applyStimulus();
        for (int k = 0; k < NS / 2; k++) begin
            clearStage();
            for (int r = 0; r < NR; r++) stageReq(r, r[0], k, 32'hBAD0_0000 | 32'(r));
            stg_flush = (k == 2);
            applyStimulus();
        end
        clearStage(); applyStimulus();
        for (int k = 0; k < NS / 2; k++) begin
            clearStage(); stageReq(0, 0, 2 * k, '0); stageReq(1, 0, 2 * k + 1, '0); applyStimulus();
        end
        clearStage(); applyStimulus();

        // Reset during the fourth flush cycle aborts without a done pulse
        for (int k = 0; k < NS / 2; k++) begin
            clearStage(); stageReq(0, 1, k, 32'h5A5A_0000 | 32'(k)); stageReq(1, 1, k + 8, 32'h7777_0000 | 32'(k));
            applyStimulus();
        end
        clearStage(); stg_flush = 1'b1; applyStimulus();
        clearStage();
        for (int k = 0; k < 3; k++) applyStimulus();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = '1;
        #1;
        checkResetOutputs("midflush");
        modelReset();
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) applyStimulus();
        for (int k = 0; k < NS / 2; k++) begin
            clearStage(); stageReq(2, 0, 2 * k, '0); stageReq(3, 0, 2 * k + 1, '0); applyStimulus();
        end
        clearStage(); applyStimulus();

        // Randomized traffic with a narrow address range to provoke hazards
        for (int c = 0; c < 500; c++) begin
            clearStage();
            for (int r = 0; r < NR; r++) begin
                stg_valid[r] = 1'($urandom_range(0, 1));
                stg_we[r]    = 1'($urandom_range(0, 1));
                stg_addr[r]  = ($urandom_range(0, 1) == 1) ? SI'($urandom_range(0, 3)) : SI'($urandom_range(0, NS - 1));
                stg_wdata[r] = $urandom;
            end
            stg_flush = ($urandom_range(0, 39) == 0);
            applyStimulus();
        end
        clearStage(); applyStimulus();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
